// File: rtl/nexys_starship_pkg.sv
// rtl/nexys_starship_pkg.sv - shared state encodings for the Nexys Starship lane controller
package nexys_starship_pkg;

   typedef enum logic [2:0] {
      INIT = 3'b001,
      PLAY = 3'b010,
      OVER = 3'b100
   } glob_state_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } lane_state_e;

   localparam int MAX_LANES  = 8;
   localparam int LANE_IDX_W = $clog2(MAX_LANES);

endpackage

// File: rtl/nexys_starship_lane.sv
// rtl/nexys_starship_lane.sv - one monster lane: spawn counter, fire timer, kill/timeout decode
module nexys_starship_lane
   import nexys_starship_pkg::*;
#(
   parameter int SPAWN_W      = 20,
   parameter int FIRE_TIMEOUT = 50_000_000,
   parameter int FIRE_W       = 26
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               en,
   input  logic               clr,
   input  logic               random,
   input  logic [SPAWN_W-1:0] thr,
   input  logic               kill,
   output logic               monster,
   output logic               killed,
   output logic               timeout
);

   localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(FIRE_TIMEOUT - 1);

   lane_state_e        state_q, state_d;
   logic [SPAWN_W-1:0] spawn_q, spawn_d;
   logic [FIRE_W-1:0]  fire_q,  fire_d;

   assign monster = (state_q == FULL);
   assign killed  = en && (state_q == FULL) && kill;
   // A kill on the final cycle outranks the timeout.
   assign timeout = en && (state_q == FULL) && !kill && (fire_q == FIRE_LAST);

   always_comb begin
      state_d = state_q;
      spawn_d = spawn_q;
      fire_d  = fire_q;
      if (!en || clr) begin
         state_d = EMPTY;
         spawn_d = '0;
         fire_d  = '0;
      end else if (state_q == EMPTY) begin
         if (random) begin
            // >= so a mid-count level increase spawns on the next enabled cycle
            if (spawn_q >= thr - SPAWN_W'(1)) begin
               state_d = FULL;
               spawn_d = '0;
               fire_d  = '0;
            end else begin
               spawn_d = spawn_q + SPAWN_W'(1);
            end
         end
      end else if (kill) begin
         state_d = EMPTY;
         fire_d  = '0;
      end else begin
         fire_d = fire_q + FIRE_W'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= EMPTY;
         spawn_q <= '0;
         fire_q  <= '0;
      end else begin
         state_q <= state_d;
         spawn_q <= spawn_d;
         fire_q  <= fire_d;
      end
   end

endmodule

// File: rtl/nexys_starship_monster_lanes.sv
// rtl/nexys_starship_monster_lanes.sv - global game FSM, lane array, over_lane encoder and score
module nexys_starship_monster_lanes
   import nexys_starship_pkg::*;
#(
   parameter int NUM_LANES    = 4,
   parameter int SPAWN_PERIOD = 1_000_000,
   parameter int SPAWN_W      = 20,
   parameter int FIRE_TIMEOUT = 50_000_000,
   parameter int FIRE_W       = 26,
   parameter int SCORE_W      = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 play_flag,
   input  logic                 restart,
   input  logic [1:0]           level,
   input  logic [NUM_LANES-1:0] lane_random,
   input  logic [NUM_LANES-1:0] kill,
   output logic [NUM_LANES-1:0] monster,
   output logic                 q_Init,
   output logic                 q_Play,
   output logic                 q_Over,
   output logic                 game_over,
   output logic [2:0]           over_lane,
   output logic [SCORE_W-1:0]   score
);

   localparam logic [SPAWN_W-1:0]   SPAWN_CFG = SPAWN_W'(SPAWN_PERIOD);
   localparam logic [SCORE_W+3:0]   SCORE_MAX = {4'b0, {SCORE_W{1'b1}}};

   glob_state_e               state_q, state_d;
   logic [SCORE_W-1:0]        score_q, score_d;
   logic [LANE_IDX_W-1:0]     over_lane_q, over_lane_d;
   logic [NUM_LANES-1:0]      killed, timeout;
   logic [SPAWN_W-1:0]        thr;
   logic                      in_play, any_timeout;
   logic [3:0]                kill_cnt;
   logic [SCORE_W+3:0]        score_sum;
   logic [LANE_IDX_W-1:0]     low_idx;

   assign in_play     = (state_q == PLAY);
   assign any_timeout = |timeout;
   assign thr         = SPAWN_CFG >> level;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      nexys_starship_lane #(
         .SPAWN_W      (SPAWN_W),
         .FIRE_TIMEOUT (FIRE_TIMEOUT),
         .FIRE_W       (FIRE_W)
      ) u_lane (
         .Clk     (Clk),
         .Reset   (Reset),
         .en      (in_play),
         .clr     (any_timeout),
         .random  (lane_random[g]),
         .thr     (thr),
         .kill    (kill[g]),
         .monster (monster[g]),
         .killed  (killed[g]),
         .timeout (timeout[g])
      );
   end

   always_comb begin
      kill_cnt = '0;
      low_idx  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         kill_cnt = kill_cnt + 4'(killed[i]);
      end
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (timeout[i]) low_idx = LANE_IDX_W'(i);
      end
      score_sum = (SCORE_W + 4)'(score_q) + (SCORE_W + 4)'(kill_cnt);
   end

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      over_lane_d = over_lane_q;
      case (state_q)
         INIT: begin
            if (play_flag) begin
               state_d     = PLAY;
               score_d     = '0;
               over_lane_d = '0;
            end
         end
         PLAY: begin
            score_d = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
            if (any_timeout) begin
               state_d     = OVER;
               over_lane_d = low_idx;
            end
         end
         OVER: begin
            if (restart) state_d = INIT;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= INIT;
         score_q     <= '0;
         over_lane_q <= '0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         over_lane_q <= over_lane_d;
      end
   end

   assign q_Init    = (state_q == INIT);
   assign q_Play    = (state_q == PLAY);
   assign q_Over    = (state_q == OVER);
   assign game_over = q_Over;
   assign over_lane = 3'(over_lane_q);
   assign score     = score_q;

endmodule

// File: tb/tb_nexys_starship_monster_lanes.sv
// tb/tb_nexys_starship_monster_lanes.sv - directed and randomized checks against a lane-game reference model
module tb_nexys_starship_monster_lanes;

   localparam int NL = 2;
   localparam int SP = 8;
   localparam int FT = 16;

   logic          Clk, Reset, play_flag, restart;
   logic [1:0]    level;
   logic [NL-1:0] lane_random, kill, monster;
   logic          q_Init, q_Play, q_Over, game_over;
   logic [2:0]    over_lane;
   logic [3:0]    score;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: game phase 0=init 1=play 2=over
   int m_st;
   bit m_full [NL];
   int m_prog [NL];
   int m_age  [NL];
   int m_score;
   int m_over;

   nexys_starship_monster_lanes #(
      .NUM_LANES(NL), .SPAWN_PERIOD(SP), .SPAWN_W(4),
      .FIRE_TIMEOUT(FT), .FIRE_W(5), .SCORE_W(4)
   ) dut (
      .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .restart(restart),
      .level(level), .lane_random(lane_random), .kill(kill), .monster(monster),
      .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over), .game_over(game_over),
      .over_lane(over_lane), .score(score)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < NL; i++) begin
         m_full[i] = 1'b0;
         m_prog[i] = 0;
         m_age[i]  = 0;
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_score = 0; m_over = 0;
      clear_lanes();
   endtask

   task automatic model_step(input logic p, input logic rs, input logic [1:0] lv,
                             input logic [NL-1:0] r, input logic [NL-1:0] k);
      int thr, kills, tmo;
      thr = SP >> lv;
      if (m_st == 0) begin
         clear_lanes();
         if (p) begin m_st = 1; m_score = 0; m_over = 0; end
      end else if (m_st == 1) begin
         kills = 0; tmo = -1;
         for (int i = 0; i < NL; i++) begin
            if (m_full[i] && k[i]) kills++;
            else if (m_full[i] && m_age[i] == FT - 1 && tmo < 0) tmo = i;
         end
         m_score = (m_score + kills > 15) ? 15 : m_score + kills;
         if (tmo >= 0) begin
            m_st = 2; m_over = tmo;
            clear_lanes();
         end else begin
            for (int i = 0; i < NL; i++) begin
               if (m_full[i]) begin
                  if (k[i]) begin m_full[i] = 1'b0; m_age[i] = 0; end
                  else m_age[i]++;
               end else if (r[i]) begin
                  if (m_prog[i] + 1 >= thr) begin
                     m_full[i] = 1'b1; m_prog[i] = 0; m_age[i] = 0;
                  end else m_prog[i]++;
               end
            end
         end
      end else begin
         clear_lanes();
         if (rs) m_st = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [NL-1:0] em;
      for (int i = 0; i < NL; i++) em[i] = m_full[i];
      chk({tag, ".monster"},   32'(monster),   32'(em));
      chk({tag, ".q_Init"},    32'(q_Init),    32'(m_st == 0));
      chk({tag, ".q_Play"},    32'(q_Play),    32'(m_st == 1));
      chk({tag, ".q_Over"},    32'(q_Over),    32'(m_st == 2));
      chk({tag, ".game_over"}, 32'(game_over), 32'(m_st == 2));
      chk({tag, ".over_lane"}, 32'(over_lane), 32'(m_over));
      chk({tag, ".score"},     32'(score),     32'(m_score));
   endtask

   task automatic step(input string tag, input logic p, input logic rs, input logic [1:0] lv,
                       input logic [NL-1:0] r, input logic [NL-1:0] k);
      play_flag = p; restart = rs; level = lv; lane_random = r; kill = k;
      @(posedge Clk);
      model_step(p, rs, lv, r, k);
      #1;
      compare_all(tag);
   endtask

   task automatic do_reset(input string tag);
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      compare_all({tag, ".async"});
      @(posedge Clk);
      #1;
      compare_all({tag, ".held"});
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; play_flag = 0; restart = 0; level = 0; lane_random = 0; kill = 0;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      compare_all("reset");
      chk("reset.q_Init_const", 32'(q_Init), 32'd1);
      chk("reset.score_const",  32'(score),  32'd0);
      Reset = 1'b0;

      // level 0: lane0 spawns on its 8th enabled edge, lane1 idle
      for (int i = 0; i < 9; i++) step("spawn8", 1, 0, 0, 2'b01, 2'b00);
      chk("spawn8.monster_const", 32'(monster), 32'h1);

      // level 2: both full, double kill
      for (int i = 0; i < 2; i++) step("lvl2", 1, 0, 2, 2'b11, 2'b00);
      chk("lvl2.monster_const", 32'(monster), 32'h3);
      step("dblkill", 1, 0, 2, 2'b00, 2'b11);
      chk("dblkill.score_const", 32'(score), 32'd2);
      chk("dblkill.monster_const", 32'(monster), 32'h0);

      // lane0 unkilled timeout
      for (int i = 0; i < 2; i++) step("to0.spawn", 1, 0, 2, 2'b01, 2'b00);
      for (int i = 0; i < FT; i++) step("to0.wait", 0, 0, 2, 2'b00, 2'b00);
      chk("to0.game_over_const", 32'(game_over), 32'd1);
      chk("to0.over_lane_const", 32'(over_lane), 32'd0);
      step("to0.restart", 0, 1, 2, 2'b00, 2'b00);
      chk("to0.q_Init_const", 32'(q_Init), 32'd1);

      // kill on the exact timeout edge
      step("ktime.play", 1, 0, 2, 2'b00, 2'b00);
      for (int i = 0; i < 2; i++) step("ktime.spawn", 1, 0, 2, 2'b01, 2'b00);
      for (int i = 0; i < FT - 1; i++) step("ktime.wait", 1, 0, 2, 2'b00, 2'b00);
      step("ktime.kill", 1, 0, 2, 2'b00, 2'b01);
      chk("ktime.score_const", 32'(score), 32'd1);
      chk("ktime.game_over_const", 32'(game_over), 32'd0);

      // both lanes time out together
      for (int i = 0; i < 2; i++) step("both.spawn", 1, 0, 2, 2'b11, 2'b00);
      for (int i = 0; i < FT; i++) step("both.wait", 0, 0, 2, 2'b00, 2'b00);
      chk("both.over_lane_const", 32'(over_lane), 32'd0);

      // lane1 alone times out
      step("to1.restart", 0, 1, 2, 2'b00, 2'b00);
      step("to1.play", 1, 0, 2, 2'b00, 2'b00);
      for (int i = 0; i < 2; i++) step("to1.spawn", 1, 0, 2, 2'b10, 2'b00);
      for (int i = 0; i < FT; i++) step("to1.wait", 0, 0, 2, 2'b00, 2'b00);
      chk("to1.over_lane_const", 32'(over_lane), 32'd1);

      // empty-lane kill, then saturation
      step("sat.restart", 0, 1, 2, 2'b00, 2'b00);
      step("sat.play", 1, 0, 2, 2'b00, 2'b00);
      step("sat.emptykill", 1, 0, 2, 2'b00, 2'b11);
      chk("sat.emptykill_const", 32'(score), 32'd0);
      for (int n = 0; n < 17; n++) begin
         for (int i = 0; i < 2; i++) step("sat.spawn", 1, 0, 2, 2'b01, 2'b00);
         step("sat.kill", 1, 0, 2, 2'b00, 2'b01);
      end
      chk("sat.score_const", 32'(score), 32'hF);

      // reset mid-play with lanes full
      for (int i = 0; i < 2; i++) step("midrst.spawn", 1, 0, 2, 2'b11, 2'b00);
      do_reset("midrst");
      chk("midrst.monster_const", 32'(monster), 32'h0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset("rnd.rst");
         end else begin
            logic [NL-1:0] r, k;
            for (int i = 0; i < NL; i++) begin
               r[i] = ($urandom_range(0, 1) == 1);
               k[i] = ($urandom_range(0, 11) == 0);
            end
            if ($urandom_range(0, 49) == 0) level = 2'($urandom_range(0, 3));
            step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), level, r, k);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
